// File: rtl/ascon_perm_sched.sv
// Purpose : command scheduler driving the 320-bit ASCON state register and round-iterative permutation core.
// Latency : LOAD/XOR/NOP and rejected commands finish 1 cycle after accept; a legal PERM nr finishes after nr cycles.
// Backpressure: cmd_ready is high only in IDLE. cmd_valid held while busy is ignored, and nothing is queued.
//
// Optional feature: define ASCON_PERM_ABORT_EN to add the 'abort' input, which terminates a PERM early.
//
// Ports:
//   clk, rst_n                                    clock and async active-low reset
//   cmd_valid/cmd_ready                           command handshake
//   cmd_op, cmd_rounds, cmd_word, cmd_data        command fields (LOAD=00, XOR=01, PERM=10, NOP=11)
//   load_init, xor_enable, xor_position, xor_data state register controls
//   permutation_valid                             state register captures the round output this cycle
//   round_const                                   round constant for the permutation core
//   busy, done, err                               status outputs; done and err are 1-cycle pulses
//   abort (ASCON_PERM_ABORT_EN only)              terminates a PERM after the current round
module ascon_perm_sched #(
  parameter int MAX_ROUNDS = 12,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ROUND_W-1:0] cmd_rounds,
  input  logic [2:0]         cmd_word,
  input  logic [63:0]        cmd_data,
  output logic               load_init,
  output logic               xor_enable,
  output logic [2:0]         xor_position,
  output logic [63:0]        xor_data,
  output logic               permutation_valid,
  output logic [7:0]         round_const,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef ASCON_PERM_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_PERM = 2'b10;

  localparam logic [ROUND_W-1:0] MAX_R    = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(MAX_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [2:0]         word_q;
  logic [63:0]        data_q;
  logic               bad_q;
  logic [ROUND_W-1:0] idx_q;

  logic accept;
  logic cmd_bad;
  logic abort_w;

`ifdef ASCON_PERM_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept = cmd_valid && (state_q == IDLE);

  // Rejected commands: an XOR to a word outside x0..x4, or a PERM whose round
  // count is outside 1..MAX_ROUNDS. Both are routed through EXEC, which
  // raises done+err without raising any strobe.
  assign cmd_bad = ((cmd_op == OP_XOR)  && (cmd_word > 3'd4)) ||
                   ((cmd_op == OP_PERM) && ((cmd_rounds == '0) || (cmd_rounds > MAX_R)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fields are captured on accept, so cmd_* may change freely afterwards.
  // The round index starts at MAX_ROUNDS-nr, which makes the final round
  // always index MAX_ROUNDS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      word_q <= '0;
      data_q <= '0;
      bad_q  <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      word_q <= cmd_word;
      data_q <= cmd_data;
      bad_q  <= cmd_bad;
      idx_q  <= MAX_R - cmd_rounds;
    end else if (state_q == ROUND) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  // All strobes decode from registered state and fields. cmd_* affect only
  // the next state, never an output in the same cycle.
  always_comb begin
    state_d           = state_q;
    cmd_ready         = 1'b0;
    load_init         = 1'b0;
    xor_enable        = 1'b0;
    xor_position      = '0;
    xor_data          = '0;
    permutation_valid = 1'b0;
    round_const       = '0;
    busy              = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = ((cmd_op == OP_PERM) && !cmd_bad) ? ROUND : EXEC;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        done       = 1'b1;
        err        = bad_q;
        load_init  = (op_q == OP_LOAD);
        xor_enable = (op_q == OP_XOR) && !bad_q;
        if (xor_enable) begin
          xor_position = word_q;
          xor_data     = data_q;
        end
        state_d = IDLE;
      end
      ROUND: begin
        busy              = 1'b1;
        permutation_valid = 1'b1;
        round_const       = {4'hF - idx_q[3:0], idx_q[3:0]};
        // An abort still lets the current round's output be captured.
        if ((idx_q == LAST_IDX) || abort_w) begin
          done    = 1'b1;
          err     = abort_w;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_sched.sv
module tb_ascon_perm_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b11;
  logic [3:0]  cmd_rounds = 4'd0;
  logic [2:0]  cmd_word = 3'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        load_init, xor_enable, permutation_valid, busy, done, err;
  logic [2:0]  xor_position;
  logic [63:0] xor_data;
  logic [7:0]  round_const;
  logic        abort = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rc_tbl [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  ascon_perm_sched #(.MAX_ROUNDS(12), .ROUND_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rounds(cmd_rounds), .cmd_word(cmd_word), .cmd_data(cmd_data),
    .load_init(load_init), .xor_enable(xor_enable), .xor_position(xor_position),
    .xor_data(xor_data), .permutation_valid(permutation_valid), .round_const(round_const),
    .busy(busy), .done(done), .err(err)
`ifdef ASCON_PERM_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic issue(input logic [1:0] op, input logic [3:0] nr,
                       input logic [2:0] w, input logic [63:0] d);
    cmd_op = op; cmd_rounds = nr; cmd_word = w; cmd_data = d; cmd_valid = 1'b1;
    chk("ready_at_issue", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_strb"},  {61'd0, load_init, xor_enable, permutation_valid}, 64'd0);
    chk({tag, "_done"},  {62'd0, done, err}, 64'd0);
    chk({tag, "_rc"},    {56'd0, round_const}, 64'd0);
    chk({tag, "_xd"},    xor_data, 64'd0);
  endtask

  // Checks the strobes of a rejected command in its EXEC cycle, then the
  // return to IDLE one cycle later.
  task automatic chk_reject(input string tag);
    chk({tag, "_doneerr"}, {62'd0, done, err}, 64'd3);
    chk({tag, "_strb"}, {61'd0, load_init, xor_enable, permutation_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    step();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    step();
    chk_idle("post_reset");

    // LOAD, then XOR word 2
    issue(2'b00, 4'd0, 3'd0, 64'd0);
    chk("load_init", {63'd0, load_init}, 64'd1);
    chk("load_done", {62'd0, done, err}, 64'd2);
    chk("load_xen", {63'd0, xor_enable}, 64'd0);
    chk("load_ready", {63'd0, cmd_ready}, 64'd0);
    step();
    chk("load_end", {63'd0, load_init}, 64'd0);
    issue(2'b01, 4'd0, 3'd2, 64'hDEADBEEF00000001);
    chk("xor_en", {63'd0, xor_enable}, 64'd1);
    chk("xor_pos", {61'd0, xor_position}, 64'd2);
    chk("xor_data", xor_data, 64'hDEADBEEF00000001);
    chk("xor_done", {62'd0, done, err}, 64'd2);
    chk("xor_load", {63'd0, load_init}, 64'd0);
    step();
    chk_idle("xor_after");

    // NOP
    issue(2'b11, 4'd0, 3'd0, 64'hFFFF);
    chk("nop_done", {62'd0, done, err}, 64'd2);
    chk("nop_strb", {61'd0, load_init, xor_enable, permutation_valid}, 64'd0);
    step();

    // PERM 12
    issue(2'b10, 4'd12, 3'd0, 64'd0);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("p12_pv%0d", k), {63'd0, permutation_valid}, 64'd1);
      chk($sformatf("p12_rc%0d", k), {56'd0, round_const}, {56'd0, rc_tbl[k]});
      chk($sformatf("p12_done%0d", k), {62'd0, done, err}, (k == 11) ? 64'd2 : 64'd0);
      chk($sformatf("p12_rdy%0d", k), {63'd0, cmd_ready}, 64'd0);
      step();
    end
    chk_idle("p12_after");

    // PERM 6 with cmd_valid held high (as a LOAD) while busy
    cmd_op = 2'b10; cmd_rounds = 4'd6; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'b00;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("p6_pv%0d", k), {63'd0, permutation_valid}, 64'd1);
      chk($sformatf("p6_rc%0d", k), {56'd0, round_const}, {56'd0, rc_tbl[6 + k]});
      chk($sformatf("p6_rdy%0d", k), {63'd0, cmd_ready}, 64'd0);
      chk($sformatf("p6_load%0d", k), {63'd0, load_init}, 64'd0);
      chk($sformatf("p6_done%0d", k), {62'd0, done, err}, (k == 5) ? 64'd2 : 64'd0);
      if (k == 5) cmd_valid = 1'b0;
      step();
    end
    chk_idle("p6_after");
    step();
    chk_idle("p6_noextra");

    // Rejected commands
    issue(2'b10, 4'd0, 3'd0, 64'd0);
    chk_reject("perm0");
    issue(2'b10, 4'd13, 3'd0, 64'd0);
    chk_reject("perm13");
    issue(2'b01, 4'd0, 3'd5, 64'h1234);
    chk("xor5_xd", xor_data, 64'd0);
    chk_reject("xor5");

    // Reset asserted during round 3 of PERM 12
    issue(2'b10, 4'd12, 3'd0, 64'd0);
    step();
    step();
    chk("rst_pre_rc", {56'd0, round_const}, 64'hd2);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_pv%0d", k), {63'd0, permutation_valid}, 64'd0);
      chk($sformatf("rst_rdy%0d", k), {63'd0, cmd_ready}, 64'd1);
    end

`ifdef ASCON_PERM_ABORT_EN
    // Abort in round 4 of PERM 12
    issue(2'b10, 4'd12, 3'd0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ab_pv%0d", k), {63'd0, permutation_valid}, 64'd1);
      chk($sformatf("ab_done%0d", k), {62'd0, done, err}, 64'd0);
      step();
    end
    abort = 1'b1;
    #1;
    chk("ab_pv4", {63'd0, permutation_valid}, 64'd1);
    chk("ab_rc4", {56'd0, round_const}, 64'hc3);
    chk("ab_doneerr", {62'd0, done, err}, 64'd3);
    step();
    abort = 1'b0;
    chk_idle("ab_after");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
